cell_comm_link_monitor: RTL

- Per-link health and statistics engine for the cell-communication Aurora links, generalised from the fixed two-link CCW/CW arrangement to NCHAN links sharing one Aurora user clock.
- For each link it counts CRC failures, good frames, channel-up drops and receive-watchdog timeouts, and tracks link state with a small FSM.
- Counters are parametrised in width and can saturate or wrap; software clears them per channel.
- Sits beside the Aurora link instances; its outputs feed the system CSR readback after a CDC stage that lives elsewhere.

---
 rtl/cell_comm_link_monitor_pkg.sv | 30 +++
 rtl/cell_comm_link_monitor_chan.sv | 129 ++++++++++++
 rtl/cell_comm_link_monitor.sv | 53 +++++
 3 files changed

// File: rtl/cell_comm_link_monitor_pkg.sv
// Shared definitions for the cell-communication link monitor: link-state
// encodings and the statistics-counter increment helper.
package cell_comm_link_monitor_pkg;

    localparam int unsigned LINK_STATE_WIDTH = 2;

    localparam logic [LINK_STATE_WIDTH-1:0] DOWN       = 2'd0;
    localparam logic [LINK_STATE_WIDTH-1:0] WAIT_FIRST = 2'd1;
    localparam logic [LINK_STATE_WIDTH-1:0] RUNNING    = 2'd2;
    localparam logic [LINK_STATE_WIDTH-1:0] STALE      = 2'd3;

    // Counters up to this width are supported by cntIncr.
    localparam int unsigned CNT_MAX_WIDTH = 64;

    // Next value of a width-bit counter: sticks at all-ones when saturate is
    // set, otherwise wraps to zero. Operates on a zero-extended value.
    function automatic logic [CNT_MAX_WIDTH-1:0] cntIncr(
        input logic [CNT_MAX_WIDTH-1:0] value,
        input int unsigned              width,
        input bit                       saturate
    );
        logic [CNT_MAX_WIDTH-1:0] maxVal;
        maxVal = (width >= CNT_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        if (value >= maxVal) begin
            return saturate ? maxVal : '0;
        end
        return value + 64'd1;
    endfunction

endpackage

// File: rtl/cell_comm_link_monitor_chan.sv
// One monitored link: link-state FSM, receive watchdog, and the four
// statistics counters (CRC faults, good frames, link drops, timeouts).
module cell_comm_link_monitor_chan
    import cell_comm_link_monitor_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned SATURATE      = 1
) (
    input  logic                        auUserClk,
    input  logic                        auUserResetN,
    input  logic                        channelUp,
    input  logic                        rxTvalid,
    input  logic                        rxTlast,
    input  logic                        rxCRCvalid,
    input  logic                        rxCRCpass,
    input  logic [TIMEOUT_WIDTH-1:0]    timeoutLimit,
    input  logic                        clear,
    output logic [CNT_WIDTH-1:0]        crcFaults,
    output logic [CNT_WIDTH-1:0]        goodFrames,
    output logic [CNT_WIDTH-1:0]        linkDrops,
    output logic [CNT_WIDTH-1:0]        timeouts,
    output logic [LINK_STATE_WIDTH-1:0] linkState,
    output logic                        faultPulse
);

    logic                        frameEnd;
    logic                        wdExpired;
    logic                        crcFailEv;
    logic                        goodEv;
    logic                        dropEv;
    logic                        timeoutEv;
    logic [LINK_STATE_WIDTH-1:0] stateNext;
    logic [TIMEOUT_WIDTH-1:0]    watchdog;
    logic [TIMEOUT_WIDTH-1:0]    watchdogNext;

    assign frameEnd  = rxTvalid & rxTlast;
    // >= rather than == so a limit lowered below the running count fires at once.
    assign wdExpired = (timeoutLimit != '0) && (watchdog >= timeoutLimit);
    assign crcFailEv = channelUp & rxCRCvalid & ~rxCRCpass;
    assign goodEv    = channelUp & rxCRCvalid &  rxCRCpass;

    // Next link state, watchdog value, and drop/timeout events.
    always_comb begin
        stateNext    = linkState;
        watchdogNext = watchdog;
        dropEv       = 1'b0;
        timeoutEv    = 1'b0;
        if (!channelUp) begin
            stateNext    = DOWN;
            watchdogNext = '0;
            dropEv       = (linkState != DOWN);
        end else begin
            case (linkState)
                DOWN: begin
                    stateNext    = WAIT_FIRST;
                    watchdogNext = '0;
                end
                WAIT_FIRST: begin
                    if (frameEnd) begin
                        stateNext = RUNNING;
                    end
                end
                RUNNING: begin
                    if (frameEnd) begin
                        watchdogNext = '0;
                    end else if (wdExpired) begin
                        stateNext = STALE;
                        timeoutEv = 1'b1;
                    end else if (watchdog != '1) begin
                        watchdogNext = watchdog + 1'b1;
                    end
                end
                STALE: begin
                    if (frameEnd) begin
                        stateNext    = RUNNING;
                        watchdogNext = '0;
                    end
                end
                default: begin
                    stateNext    = DOWN;
                    watchdogNext = '0;
                end
            endcase
        end
    end

    // Link state, watchdog and the combined fault pulse.
    always_ff @(posedge auUserClk or negedge auUserResetN) begin
        if (!auUserResetN) begin
            linkState  <= DOWN;
            watchdog   <= '0;
            faultPulse <= 1'b0;
        end else begin
            linkState  <= stateNext;
            watchdog   <= watchdogNext;
            faultPulse <= crcFailEv | timeoutEv | dropEv;
        end
    end

    // Statistics counters; a clear discards any same-cycle increment.
    always_ff @(posedge auUserClk or negedge auUserResetN) begin
        if (!auUserResetN) begin
            crcFaults  <= '0;
            goodFrames <= '0;
            linkDrops  <= '0;
            timeouts   <= '0;
        end else if (clear) begin
            crcFaults  <= '0;
            goodFrames <= '0;
            linkDrops  <= '0;
            timeouts   <= '0;
        end else begin
            if (crcFailEv) begin
                crcFaults <= CNT_WIDTH'(cntIncr(CNT_MAX_WIDTH'(crcFaults), CNT_WIDTH, SATURATE != 0));
            end
            if (goodEv) begin
                goodFrames <= CNT_WIDTH'(cntIncr(CNT_MAX_WIDTH'(goodFrames), CNT_WIDTH, SATURATE != 0));
            end
            if (dropEv) begin
                linkDrops <= CNT_WIDTH'(cntIncr(CNT_MAX_WIDTH'(linkDrops), CNT_WIDTH, SATURATE != 0));
            end
            if (timeoutEv) begin
                timeouts <= CNT_WIDTH'(cntIncr(CNT_MAX_WIDTH'(timeouts), CNT_WIDTH, SATURATE != 0));
            end
        end
    end

endmodule

// File: rtl/cell_comm_link_monitor.sv
// Health and statistics monitor for NCHAN Aurora links on a shared user
// clock. One independent channel instance per link; outputs are packed
// with channel i at slice i.
module cell_comm_link_monitor
    import cell_comm_link_monitor_pkg::*;
#(
    parameter int unsigned NCHAN         = 2,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned SATURATE      = 1
) (
    input  logic                              auUserClk,
    input  logic                              auUserResetN,
    input  logic [NCHAN-1:0]                  channelUp,
    input  logic [NCHAN-1:0]                  rxTvalid,
    input  logic [NCHAN-1:0]                  rxTlast,
    input  logic [NCHAN-1:0]                  rxCRCvalid,
    input  logic [NCHAN-1:0]                  rxCRCpass,
    input  logic [TIMEOUT_WIDTH-1:0]          timeoutLimit,
    input  logic [NCHAN-1:0]                  clearMask,
    output logic [NCHAN*CNT_WIDTH-1:0]        crcFaults,
    output logic [NCHAN*CNT_WIDTH-1:0]        goodFrames,
    output logic [NCHAN*CNT_WIDTH-1:0]        linkDrops,
    output logic [NCHAN*CNT_WIDTH-1:0]        timeouts,
    output logic [NCHAN*LINK_STATE_WIDTH-1:0] linkState,
    output logic [NCHAN-1:0]                  faultPulse
);

    for (genvar i = 0; i < NCHAN; i++) begin : gChan
        cell_comm_link_monitor_chan #(
            .CNT_WIDTH     (CNT_WIDTH),
            .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
            .SATURATE      (SATURATE)
        ) uChan (
            .auUserClk    (auUserClk),
            .auUserResetN (auUserResetN),
            .channelUp    (channelUp[i]),
            .rxTvalid     (rxTvalid[i]),
            .rxTlast      (rxTlast[i]),
            .rxCRCvalid   (rxCRCvalid[i]),
            .rxCRCpass    (rxCRCpass[i]),
            .timeoutLimit (timeoutLimit),
            .clear        (clearMask[i]),
            .crcFaults    (crcFaults[i*CNT_WIDTH +: CNT_WIDTH]),
            .goodFrames   (goodFrames[i*CNT_WIDTH +: CNT_WIDTH]),
            .linkDrops    (linkDrops[i*CNT_WIDTH +: CNT_WIDTH]),
            .timeouts     (timeouts[i*CNT_WIDTH +: CNT_WIDTH]),
            .linkState    (linkState[i*LINK_STATE_WIDTH +: LINK_STATE_WIDTH]),
            .faultPulse   (faultPulse[i])
        );
    end

endmodule
